// File: rtl/key_debounce_sync.sv
`timescale 1ns/1ps
// key_debounce_sync: synchronise a raw bouncing key/line and debounce it into a clean level.
// Latency: a clean step sampled at edge k appears on data_o at edge k+SYNC_STAGES+CNT_MAX.
// Backpressure: none; the input is sampled every cycle and the outputs are plain levels/pulses.
//
// Ports:
//   sys_clk    - system clock, rising edge
//   sys_rst_n  - asynchronous active-low reset
//   key_in     - raw asynchronous input, may bounce
//   data_o     - debounced synchronous level (registered, glitch-free)
//   rise_pulse - one-cycle pulse coincident with the first high cycle of data_o
//   fall_pulse - one-cycle pulse coincident with the first low cycle of data_o
//   busy       - high while the FSM is filtering a candidate change
//
// Build option: define KEY_EDGE_PULSE_EN to build the edge-pulse flops; otherwise
// rise_pulse/fall_pulse are tied low and the port list is unchanged.
module key_debounce_sync #(
  parameter int unsigned CNT_MAX     = 999_999,
  parameter int unsigned CNT_W       = 20,
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic        IDLE_LEVEL  = 1'b0
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic key_in,
  output logic data_o,
  output logic rise_pulse,
  output logic fall_pulse,
  output logic busy
);

  typedef enum logic [1:0] {
    IDLE_LOW    = 2'b00,
    FILTER_UP   = 2'b01,
    IDLE_HIGH   = 2'b11,
    FILTER_DOWN = 2'b10
  } state_e;

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CNT_MAX - 1);
  localparam state_e           RST_STATE = IDLE_LEVEL ? IDLE_HIGH : IDLE_LOW;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   key_s;
  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   data_q, data_d;

  // Plain flop chain: no logic between stages so metastability can settle.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      sync_q <= {SYNC_STAGES{IDLE_LEVEL}};
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], key_in};
    end
  end

  assign key_s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q <= RST_STATE;
      cnt_q   <= '0;
      data_q  <= IDLE_LEVEL;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
    end
  end

  // The abort test comes before the terminal-count test, so a return to the
  // old level on the final count cycle cancels the change.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    case (state_q)
      IDLE_LOW: begin
        cnt_d = '0;
        if (key_s) state_d = FILTER_UP;
      end
      FILTER_UP: begin
        if (!key_s) begin
          state_d = IDLE_LOW;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE_HIGH;
          data_d  = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      IDLE_HIGH: begin
        cnt_d = '0;
        if (!key_s) state_d = FILTER_DOWN;
      end
      FILTER_DOWN: begin
        if (key_s) begin
          state_d = IDLE_HIGH;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE_LOW;
          data_d  = 1'b0;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        // Corrupted state: fall back to the idle state that agrees with data_o.
        state_d = data_q ? IDLE_HIGH : IDLE_LOW;
        cnt_d   = '0;
      end
    endcase
  end

  assign data_o = data_q;
  assign busy   = (state_q == FILTER_UP) || (state_q == FILTER_DOWN);

`ifdef KEY_EDGE_PULSE_EN
  logic rise_q, fall_q;

  // Registered on the same edge that updates data_q, so each pulse lines up
  // with the first cycle of the new level.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      rise_q <= data_d & ~data_q;
      fall_q <= ~data_d & data_q;
    end
  end

  assign rise_pulse = rise_q;
  assign fall_pulse = fall_q;
`else
  assign rise_pulse = 1'b0;
  assign fall_pulse = 1'b0;
`endif

endmodule

// File: tb/tb_key_debounce_sync.sv
`timescale 1ns/1ps
// Bench for key_debounce_sync (CNT_MAX=5, SYNC_STAGES=2, IDLE_LEVEL=0, 20 ns clock).
// Expected data_o changes and edge pulses are queued with their edge number when
// the stimulus is driven and matched by a monitor when the DUT produces them.
module tb_key_debounce_sync;

  localparam int LAT = 7; // SYNC_STAGES + CNT_MAX

  logic sys_clk = 1'b0;
  logic sys_rst_n;
  logic key_in;
  logic data_o, rise_pulse, fall_pulse, busy;

  key_debounce_sync #(
    .CNT_MAX    (5),
    .CNT_W      (3),
    .SYNC_STAGES(2),
    .IDLE_LEVEL (1'b0)
  ) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .key_in    (key_in),
    .data_o    (data_o),
    .rise_pulse(rise_pulse),
    .fall_pulse(fall_pulse),
    .busy      (busy)
  );

  always #10 sys_clk = ~sys_clk;

  typedef struct {
    int   edge_n;
    logic lvl;
  } ev_t;

  ev_t dq[$];   // expected data_o changes
  ev_t pq[$];   // expected pulses (lvl=1 rise, lvl=0 fall)
  int  checks = 0;
  int  errors = 0;
  int  cyc    = 0;

  always @(posedge sys_clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Return at the falling edge that follows rising edge number e.
  task automatic wait_edge(input int e);
    while (cyc < e) @(negedge sys_clk);
  endtask

  task automatic expect_change(input int e, input logic lvl);
    ev_t ev;
    ev.edge_n = e;
    ev.lvl    = lvl;
    dq.push_back(ev);
`ifdef KEY_EDGE_PULSE_EN
    pq.push_back(ev);
`endif
  endtask

  // Monitor: every data_o change and every pulse must match the queue head.
  logic prev_data = 1'b0;
  ev_t  mon_ev;
  always @(negedge sys_clk) begin
    if (data_o !== prev_data) begin
      checks++;
      assert (dq.size() > 0) else begin
        errors++;
        $error("FAIL unexpected_data_change: observed %0d at edge %0d expected no change", data_o, cyc);
      end
      if (dq.size() > 0) begin
        mon_ev = dq.pop_front();
        check("data_change_edge", cyc, mon_ev.edge_n);
        check("data_change_level", data_o, mon_ev.lvl);
      end
      prev_data = data_o;
    end
    if (rise_pulse === 1'b1 || fall_pulse === 1'b1) begin
      checks++;
      assert (pq.size() > 0) else begin
        errors++;
        $error("FAIL unexpected_pulse: observed rise=%0d fall=%0d at edge %0d expected none",
               rise_pulse, fall_pulse, cyc);
      end
      if (pq.size() > 0) begin
        mon_ev = pq.pop_front();
        check("pulse_edge", cyc, mon_ev.edge_n);
        check("rise_pulse_val", rise_pulse, mon_ev.lvl);
        check("fall_pulse_val", fall_pulse, !mon_ev.lvl);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int k;
    sys_rst_n = 1'b1;
    key_in    = 1'b1;
    #1 sys_rst_n = 1'b0;

    // Reset with key_in high: outputs must sit at idle throughout.
    #4;
    check("rst_data", data_o, 0);
    check("rst_busy", busy, 0);
    check("rst_pulses", {rise_pulse, fall_pulse}, 0);
    repeat (2) begin
      @(negedge sys_clk);
      check("rst_hold_data", data_o, 0);
      check("rst_hold_busy", busy, 0);
      check("rst_hold_pulses", {rise_pulse, fall_pulse}, 0);
    end
    #1;
    sys_rst_n = 1'b1;
    key_in    = 1'b0;
    @(negedge sys_clk);
    wait_edge(cyc + 3);

    // Clean rise.
    k = cyc + 1;
    key_in = 1'b1;
    expect_change(k + LAT, 1'b1);
    wait_edge(k + 1); check("rise_busy_before", busy, 0);
    wait_edge(k + 2); check("rise_busy_start", busy, 1);
    wait_edge(k + 6); check("rise_cnt_last", 32'(dut.cnt_q), 4);
                      check("rise_data_pre", data_o, 0);
    wait_edge(k + 7); check("rise_data", data_o, 1);
                      check("rise_busy_end", busy, 0);
    wait_edge(k + 8); check("rise_pulse_gone", rise_pulse, 0);
    wait_edge(k + 10);

    // Clean fall.
    k = cyc + 1;
    key_in = 1'b0;
    expect_change(k + LAT, 1'b0);
    wait_edge(k + 2); check("fall_busy_start", busy, 1);
    wait_edge(k + 6); check("fall_data_pre", data_o, 1);
    wait_edge(k + 7); check("fall_data", data_o, 0);
                      check("fall_busy_end", busy, 0);
    wait_edge(k + 8); check("fall_no_rise", rise_pulse, 0);
    wait_edge(k + 10);

    // High for 4 samples: aborted well before the terminal count.
    k = cyc + 1;
    key_in = 1'b1;
    wait_edge(k + 3); key_in = 1'b0;
    wait_edge(k + 5); check("abort4_busy", busy, 1);
    wait_edge(k + 6); check("abort4_idle", busy, 0);
                      check("abort4_cnt", 32'(dut.cnt_q), 0);
    wait_edge(k + 12); check("abort4_data", data_o, 0);

    // High for 5 samples: the return to low lands on the terminal-count edge.
    k = cyc + 1;
    key_in = 1'b1;
    wait_edge(k + 4); key_in = 1'b0;
    wait_edge(k + 6); check("abort5_cnt_last", 32'(dut.cnt_q), 4);
                      check("abort5_busy", busy, 1);
    wait_edge(k + 7); check("abort5_idle", busy, 0);
                      check("abort5_data", data_o, 0);
                      check("abort5_cnt", 32'(dut.cnt_q), 0);
    wait_edge(k + 12);

    // High for 6 samples: just long enough, followed by a full-length fall.
    k = cyc + 1;
    key_in = 1'b1;
    expect_change(k + LAT, 1'b1);
    expect_change(k + 6 + LAT, 1'b0);
    wait_edge(k + 5); key_in = 1'b0;
    wait_edge(k + 7);  check("min6_data_high", data_o, 1);
    wait_edge(k + 12); check("min6_data_hold", data_o, 1);
    wait_edge(k + 13); check("min6_data_low", data_o, 0);
    wait_edge(k + 16);

    // Bounce 1,0,1,0 (2 cycles each), then settle high.
    k = cyc + 1;
    key_in = 1'b1;
    wait_edge(k + 1); key_in = 1'b0;
    wait_edge(k + 3); key_in = 1'b1;
    wait_edge(k + 5); key_in = 1'b0;
    wait_edge(k + 7); key_in = 1'b1;
    k = k + 8;
    expect_change(k + LAT, 1'b1);
    wait_edge(k + 6); check("bounce_data_pre", data_o, 0);
    wait_edge(k + 7); check("bounce_data", data_o, 1);
    wait_edge(k + 10);

    k = cyc + 1;
    key_in = 1'b0;
    expect_change(k + LAT, 1'b0);
    wait_edge(k + 10);

    // Reset in the middle of FILTER_UP.
    k = cyc + 1;
    key_in = 1'b1;
    wait_edge(k + 5); check("midrst_cnt_before", 32'(dut.cnt_q), 3);
                      check("midrst_busy_before", busy, 1);
    sys_rst_n = 1'b0;
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_data", data_o, 0);
    check("midrst_cnt", 32'(dut.cnt_q), 0);
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    k = cyc + 1;
    expect_change(k + LAT, 1'b1);
    wait_edge(k + 1); check("postrst_busy_before", busy, 0);
    wait_edge(k + 2); check("postrst_busy_start", busy, 1);
    wait_edge(k + 6); check("postrst_data_pre", data_o, 0);
    wait_edge(k + 7); check("postrst_data", data_o, 1);
    wait_edge(k + 10);

    check("data_queue_drained", dq.size(), 0);
    check("pulse_queue_drained", pq.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
